imm_decode_stage: RTL

Pipelined, parametrised immediate-generation stage for the branch-predicting pipeline. Accepts one instruction plus its PC per cycle over a valid/ready handshake and decodes the immediate format. Emits the sign- or zero-extended immediate, a format code and, for branches and JAL, the precomputed target `pc + imm` for early redirect. A 2-entry skid buffer gives full throughput under backpressure, and a synchronous flush discards in-flight entries on mispredict.

---
 rtl/imm_decode_stage_if.sv | 29 ++
 rtl/imm_decode_stage.sv | 120 ++++++++++++
 2 files changed

// File: rtl/imm_decode_stage_if.sv
// Handshake bundle for the immediate-generation stage: upstream instruction/PC
// channel and downstream decoded-immediate channel.
interface imm_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_target;
    logic            out_is_branch;
    logic            out_is_jump;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_target,
               out_is_branch, out_is_jump
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_target,
               out_is_branch, out_is_jump
    );
endinterface

// File: rtl/imm_decode_stage.sv
// Immediate decode with precomputed branch/JAL target, behind a 2-entry
// main+skid buffer with synchronous flush.
module imm_decode_stage #(
    parameter int XLEN    = 32,
    parameter bit EN_ZIMM = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    output logic [1:0]          occupancy,
    imm_decode_stage_if.slave   bus
);
    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; valid never depends on ready, and in_ready comes only from buffer state.

    localparam logic [2:0] FMT_NONE = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                           FMT_U = 3'd4, FMT_J = 3'd5, FMT_Z = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [XLEN-1:0] target;
        logic            is_branch;
        logic            is_jump;
    } entry_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t state_q, state_d;
    entry_t main_q, skid_q, dec;
    logic   accept, pop, load_main, load_skid, move_skid;
    logic [31:0] instr;

    assign instr = bus.in_instr;

    always_comb begin
        dec = '0;
        unique case (instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: dec.fmt = FMT_I;
            7'b0011011: dec.fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
            7'b0100011: dec.fmt = FMT_S;
            7'b1100011: dec.fmt = FMT_B;
            7'b0110111, 7'b0010111: dec.fmt = FMT_U;
            7'b1101111: dec.fmt = FMT_J;
            7'b1110011: dec.fmt = (instr[14] && EN_ZIMM) ? FMT_Z : FMT_NONE;
            default: dec.fmt = FMT_NONE;
        endcase
        // Size casts of signed slices replicate instr[31] up to bit XLEN-1.
        case (dec.fmt)
            FMT_I: dec.imm = XLEN'($signed(instr[31:20]));
            FMT_S: dec.imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            FMT_B: dec.imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            FMT_U: dec.imm = XLEN'($signed({instr[31:12], 12'b0}));
            FMT_J: dec.imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            FMT_Z: dec.imm = XLEN'(instr[19:15]);
            default: dec.imm = '0;
        endcase
        dec.is_branch = (dec.fmt == FMT_B);
        dec.is_jump   = (dec.fmt == FMT_J);
        if (dec.is_branch || dec.is_jump) dec.target = bus.in_pc + dec.imm;
    end

    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign accept        = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
                ONE: begin
                    if (accept && pop) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (pop) begin
                    state_d   = ONE;
                    move_skid = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (flush)          main_q <= '0;
            else if (load_main) main_q <= dec;
            else if (move_skid) main_q <= skid_q;
            if (load_skid)      skid_q <= dec;
        end
    end

    assign occupancy         = state_q;
    assign bus.out_imm       = main_q.imm;
    assign bus.out_fmt       = main_q.fmt;
    assign bus.out_target    = main_q.target;
    assign bus.out_is_branch = main_q.is_branch;
    assign bus.out_is_jump   = main_q.is_jump;
endmodule
